// File: rtl/writeback_if.sv
// Data-memory req/ack bus between the writeback stage and data memory.
// The master side issues requests; the slave side answers with ack and read data.
interface writeback_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/writeback.sv
// RV32I final pipeline stage: data-memory access, load alignment/extension,
// register-file write-back and upstream stall while a bus access is in flight.
module writeback (
    input  logic                clk,
    input  logic                clr,
    input  logic                pen_p_3,
    input  logic [4:0]          rad_p_3,
    input  logic                rad_zero_p_3,
    input  logic [31:0]         alu_p_3,
    input  logic [31:0]         rd2_p_3,
    input  logic [31:0]         next_pc_p_3,
    input  logic [31:0]         instr_p_3,
    input  logic [14:0]         is_p_3,
    output logic                stall,
    writeback_if.master         dmem,
    output logic                rf_we,
    output logic [4:0]          rf_wa,
    output logic [31:0]         rf_wd,
    output logic                trap,
    output logic                retire
);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_r;
    logic [2:0]  f3_r;
    logic [1:0]  a_r;
    logic [4:0]  rad_r;
    logic        rad_zero_r;
    logic        ld_r;

    logic        dmem_req_r;
    logic        dmem_we_r;
    logic [31:0] dmem_addr_r;
    logic [3:0]  dmem_wmask_r;
    logic [31:0] dmem_wdata_r;
    logic        rf_we_r;
    logic [4:0]  rf_wa_r;
    logic [31:0] rf_wd_r;
    logic        trap_r;
    logic        retire_r;

    logic [2:0]  f3_s;
    logic [1:0]  a_s;
    logic        ld_s;
    logic        st_s;
    logic        legal_s;
    logic        aligned_s;
    logic        go_s;
    logic        stall_s;
    logic [3:0]  lane_mask_s;
    logic [31:0] wdata_s;

    // Byte lane a, halfword lane a[1]; funct3[2] selects zero- over sign-extension.
    function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                 input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h00_0000, b};
            3'b101:  return {16'h0000, h};
            default: return w;
        endcase
    endfunction

    // Decode legality, alignment, store lanes and the stall condition.
    always_comb begin
        f3_s      = instr_p_3[14:12];
        a_s       = alu_p_3[1:0];
        ld_s      = is_p_3[5];
        st_s      = is_p_3[6];
        legal_s   = 1'b0;
        aligned_s = 1'b1;
        lane_mask_s = 4'b1111;
        wdata_s     = rd2_p_3;

        if (ld_s) begin
            case (f3_s)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                default:                                legal_s = 1'b0;
            endcase
        end else if (st_s) begin
            case (f3_s)
                3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                default:                legal_s = 1'b0;
            endcase
        end else begin
            legal_s = 1'b0;
        end

        case (f3_s[1:0])
            2'b01:   aligned_s = (a_s[0] == 1'b0);
            2'b10:   aligned_s = (a_s == 2'b00);
            default: aligned_s = 1'b1;
        endcase

        case (f3_s[1:0])
            2'b00: begin
                lane_mask_s = 4'b0001 << a_s;
                wdata_s     = {4{rd2_p_3[7:0]}};
            end
            2'b01: begin
                lane_mask_s = 4'b0011 << a_s;
                wdata_s     = {2{rd2_p_3[15:0]}};
            end
            default: begin
                lane_mask_s = 4'b1111;
                wdata_s     = rd2_p_3;
            end
        endcase

        go_s    = (state_r == IDLE) && pen_p_3 && (ld_s || st_s) && legal_s && aligned_s;
        stall_s = go_s || ((state_r == ACCESS) && !dmem.dmem_ack);
    end

    // Stage FSM: issue the access, wait for ack, then write back and retire.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r      <= IDLE;
            f3_r         <= 3'b000;
            a_r          <= 2'b00;
            rad_r        <= 5'd0;
            rad_zero_r   <= 1'b0;
            ld_r         <= 1'b0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= 32'h0000_0000;
            dmem_wmask_r <= 4'b0000;
            dmem_wdata_r <= 32'h0000_0000;
            rf_we_r      <= 1'b0;
            rf_wa_r      <= 5'd0;
            rf_wd_r      <= 32'h0000_0000;
            trap_r       <= 1'b0;
            retire_r     <= 1'b0;
        end else begin
            rf_we_r  <= 1'b0;
            retire_r <= 1'b0;
            trap_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pen_p_3) begin
                        if (is_p_3[5] || is_p_3[6]) begin
                            if (legal_s && aligned_s) begin
                                f3_r         <= f3_s;
                                a_r          <= a_s;
                                rad_r        <= rad_p_3;
                                rad_zero_r   <= rad_zero_p_3;
                                ld_r         <= ld_s;
                                dmem_req_r   <= 1'b1;
                                dmem_we_r    <= st_s;
                                dmem_addr_r  <= {alu_p_3[31:2], 2'b00};
                                dmem_wmask_r <= st_s ? lane_mask_s : 4'b0000;
                                dmem_wdata_r <= wdata_s;
                                state_r      <= ACCESS;
                            end else begin
                                trap_r   <= 1'b1;
                                retire_r <= 1'b1;
                            end
                        end else begin
                            retire_r <= 1'b1;
                            rf_we_r  <= !rad_zero_p_3 && !is_p_3[6] && !is_p_3[7];
                            rf_wa_r  <= rad_p_3;
                            rf_wd_r  <= (is_p_3[8] || is_p_3[9]) ? next_pc_p_3 : alu_p_3;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_ack) begin
                        dmem_req_r <= 1'b0;
                        retire_r   <= 1'b1;
                        state_r    <= IDLE;
                        if (ld_r) begin
                            rf_we_r <= !rad_zero_r;
                            rf_wa_r <= rad_r;
                            rf_wd_r <= load_extract(f3_r, a_r, dmem.dmem_rdata);
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign stall           = stall_s;
    assign dmem.dmem_req   = dmem_req_r;
    assign dmem.dmem_we    = dmem_we_r;
    assign dmem.dmem_addr  = dmem_addr_r;
    assign dmem.dmem_wmask = dmem_wmask_r;
    assign dmem.dmem_wdata = dmem_wdata_r;
    assign rf_we           = rf_we_r;
    assign rf_wa           = rf_wa_r;
    assign rf_wd           = rf_wd_r;
    assign trap            = trap_r;
    assign retire          = retire_r;

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for the writeback stage with hand-computed expectations.
module tb_writeback;
    logic        clk;
    logic        clr;
    logic        pen_p_3;
    logic [4:0]  rad_p_3;
    logic        rad_zero_p_3;
    logic [31:0] alu_p_3;
    logic [31:0] rd2_p_3;
    logic [31:0] next_pc_p_3;
    logic [31:0] instr_p_3;
    logic [14:0] is_p_3;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        trap;
    logic        retire;

    int n_checks;
    int n_fail;

    localparam logic [14:0] IS_ALU   = 15'h0000;
    localparam logic [14:0] IS_LOAD  = 15'h0020;
    localparam logic [14:0] IS_STORE = 15'h0040;
    localparam logic [14:0] IS_BR    = 15'h0080;
    localparam logic [14:0] IS_JAL   = 15'h0100;

    writeback_if bus ();

    writeback dut (
        .clk          (clk),
        .clr          (clr),
        .pen_p_3      (pen_p_3),
        .rad_p_3      (rad_p_3),
        .rad_zero_p_3 (rad_zero_p_3),
        .alu_p_3      (alu_p_3),
        .rd2_p_3      (rd2_p_3),
        .next_pc_p_3  (next_pc_p_3),
        .instr_p_3    (instr_p_3),
        .is_p_3       (is_p_3),
        .stall        (stall),
        .dmem         (bus),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .trap         (trap),
        .retire       (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [14:0] cls, input logic [2:0] f3, input logic [4:0] rd,
                          input logic rz, input logic [31:0] alu, input logic [31:0] rd2,
                          input logic [31:0] npc);
        pen_p_3      = 1'b1;
        is_p_3       = cls;
        instr_p_3    = {17'd0, f3, 12'd0};
        rad_p_3      = rd;
        rad_zero_p_3 = rz;
        alu_p_3      = alu;
        rd2_p_3      = rd2;
        next_pc_p_3  = npc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".req"},   {31'd0, bus.dmem_req}, 32'd0);
        check({tag, ".we"},    {31'd0, bus.dmem_we},  32'd0);
        check({tag, ".addr"},  bus.dmem_addr,         32'd0);
        check({tag, ".wmask"}, {28'd0, bus.dmem_wmask}, 32'd0);
        check({tag, ".wdata"}, bus.dmem_wdata,        32'd0);
        check({tag, ".rf_we"}, {31'd0, rf_we},        32'd0);
        check({tag, ".rf_wa"}, {27'd0, rf_wa},        32'd0);
        check({tag, ".rf_wd"}, rf_wd,                 32'd0);
        check({tag, ".trap"},  {31'd0, trap},         32'd0);
        check({tag, ".retire"},{31'd0, retire},       32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with random inputs
        clr = 1'b1;
        pen_p_3 = 1'($urandom); rad_p_3 = 5'($urandom); rad_zero_p_3 = 1'($urandom);
        alu_p_3 = $urandom; rd2_p_3 = $urandom; next_pc_p_3 = $urandom;
        instr_p_3 = $urandom; is_p_3 = 15'($urandom);
        bus.dmem_ack = 1'($urandom); bus.dmem_rdata = $urandom;
        tick();
        tick();
        check_all_zero("reset");
        clr = 1'b0;
        pen_p_3 = 1'b0;
        bus.dmem_ack = 1'b0;
        #1;
        check("reset.stall", {31'd0, stall}, 32'd0);

        // ALU op, rad=5
        set_op(IS_ALU, 3'b000, 5'd5, 1'b0, 32'h1234_5678, 32'h0, 32'h0000_0104);
        #1;
        check("alu.stall", {31'd0, stall}, 32'd0);
        tick();
        pen_p_3 = 1'b0;
        check("alu.rf_we", {31'd0, rf_we}, 32'd1);
        check("alu.rf_wa", {27'd0, rf_wa}, 32'd5);
        check("alu.rf_wd", rf_wd, 32'h1234_5678);
        check("alu.retire", {31'd0, retire}, 32'd1);
        tick();
        check("alu.pulse_we", {31'd0, rf_we}, 32'd0);
        check("alu.pulse_ret", {31'd0, retire}, 32'd0);

        // ALU op to x0
        set_op(IS_ALU, 3'b000, 5'd0, 1'b1, 32'h1234_5678, 32'h0, 32'h0);
        tick();
        pen_p_3 = 1'b0;
        check("x0.rf_we", {31'd0, rf_we}, 32'd0);
        check("x0.retire", {31'd0, retire}, 32'd1);

        // JAL writes link value
        set_op(IS_JAL, 3'b000, 5'd1, 1'b0, 32'h0000_0800, 32'h0, 32'h0000_0400);
        tick();
        pen_p_3 = 1'b0;
        check("jal.rf_we", {31'd0, rf_we}, 32'd1);
        check("jal.rf_wd", rf_wd, 32'h0000_0400);

        // Branch retires without writing
        set_op(IS_BR, 3'b000, 5'd3, 1'b0, 32'h1, 32'h0, 32'h0);
        tick();
        pen_p_3 = 1'b0;
        check("br.rf_we", {31'd0, rf_we}, 32'd0);
        check("br.retire", {31'd0, retire}, 32'd1);
        tick();

        // LB at 0x103, three wait cycles
        set_op(IS_LOAD, 3'b000, 5'd9, 1'b0, 32'h0000_0103, 32'h0, 32'h0);
        bus.dmem_rdata = 32'h80FF_0000;
        #1;
        check("lb.stall0", {31'd0, stall}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("lb.stall_wait", {31'd0, stall}, 32'd1);
            check("lb.req", {31'd0, bus.dmem_req}, 32'd1);
            check("lb.addr", bus.dmem_addr, 32'h0000_0100);
            check("lb.we", {31'd0, bus.dmem_we}, 32'd0);
            check("lb.wmask", {28'd0, bus.dmem_wmask}, 32'd0);
            check("lb.no_retire", {31'd0, retire}, 32'd0);
        end
        tick();
        bus.dmem_ack = 1'b1;
        #1;
        check("lb.stall_ack", {31'd0, stall}, 32'd0);
        tick();
        bus.dmem_ack = 1'b0;
        pen_p_3 = 1'b0;
        check("lb.rf_we", {31'd0, rf_we}, 32'd1);
        check("lb.rf_wa", {27'd0, rf_wa}, 32'd9);
        check("lb.rf_wd", rf_wd, 32'hFFFF_FF80);
        check("lb.retire", {31'd0, retire}, 32'd1);
        check("lb.req_low", {31'd0, bus.dmem_req}, 32'd0);
        tick();
        check("lb.pulse_we", {31'd0, rf_we}, 32'd0);

        // LBU at 0x103, zero wait states
        set_op(IS_LOAD, 3'b100, 5'd10, 1'b0, 32'h0000_0103, 32'h0, 32'h0);
        tick();
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        pen_p_3 = 1'b0;
        check("lbu.rf_wd", rf_wd, 32'h0000_0080);
        check("lbu.rf_we", {31'd0, rf_we}, 32'd1);

        // LH at 0x102 -> upper halfword sign-extended
        set_op(IS_LOAD, 3'b001, 5'd11, 1'b0, 32'h0000_0102, 32'h0, 32'h0);
        tick();
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        pen_p_3 = 1'b0;
        check("lh.rf_wd", rf_wd, 32'hFFFF_80FF);

        // SH at 0x202
        set_op(IS_STORE, 3'b001, 5'd0, 1'b0, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0);
        tick();
        check("sh.req", {31'd0, bus.dmem_req}, 32'd1);
        check("sh.we", {31'd0, bus.dmem_we}, 32'd1);
        check("sh.addr", bus.dmem_addr, 32'h0000_0200);
        check("sh.wmask", {28'd0, bus.dmem_wmask}, 32'h0000_000C);
        check("sh.wdata", bus.dmem_wdata, 32'hBEEF_BEEF);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        pen_p_3 = 1'b0;
        check("sh.rf_we", {31'd0, rf_we}, 32'd0);
        check("sh.retire", {31'd0, retire}, 32'd1);

        // SB at 0x301
        set_op(IS_STORE, 3'b000, 5'd0, 1'b0, 32'h0000_0301, 32'h1234_56A5, 32'h0);
        tick();
        check("sb.wmask", {28'd0, bus.dmem_wmask}, 32'h0000_0002);
        check("sb.wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        pen_p_3 = 1'b0;
        tick();

        // Misaligned LW at 0x101
        set_op(IS_LOAD, 3'b010, 5'd12, 1'b0, 32'h0000_0101, 32'h0, 32'h0);
        #1;
        check("mis.stall", {31'd0, stall}, 32'd0);
        tick();
        pen_p_3 = 1'b0;
        check("mis.trap", {31'd0, trap}, 32'd1);
        check("mis.retire", {31'd0, retire}, 32'd1);
        check("mis.req", {31'd0, bus.dmem_req}, 32'd0);
        check("mis.rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        check("mis.trap_pulse", {31'd0, trap}, 32'd0);

        // Illegal store funct3
        set_op(IS_STORE, 3'b011, 5'd0, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
        tick();
        pen_p_3 = 1'b0;
        check("ill.trap", {31'd0, trap}, 32'd1);
        check("ill.req", {31'd0, bus.dmem_req}, 32'd0);
        tick();

        // clr during ACCESS, then a late ack
        set_op(IS_LOAD, 3'b010, 5'd13, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
        tick();
        check("clr.req_before", {31'd0, bus.dmem_req}, 32'd1);
        clr = 1'b1;
        pen_p_3 = 1'b0;
        tick();
        check_all_zero("clr");
        clr = 1'b0;
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        check("clr.late_rf_we", {31'd0, rf_we}, 32'd0);
        check("clr.late_retire", {31'd0, retire}, 32'd0);
        check("clr.late_req", {31'd0, bus.dmem_req}, 32'd0);

        // Normal ALU op after clr
        set_op(IS_ALU, 3'b000, 5'd7, 1'b0, 32'h0000_CAFE, 32'h0, 32'h0);
        tick();
        pen_p_3 = 1'b0;
        check("post.rf_we", {31'd0, rf_we}, 32'd1);
        check("post.rf_wa", {27'd0, rf_wa}, 32'd7);
        check("post.rf_wd", rf_wd, 32'h0000_CAFE);
        check("post.retire", {31'd0, retire}, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback.md
# writeback

Final pipeline stage of the RV32I core, directly downstream of the `memory` stage register. It performs the data-memory access for loads and stores over a simple req/ack bus and aligns and sign-extends load data. It selects the register-file write value and drives the single register-file write port. While a bus access is outstanding it stalls the upstream pipeline.

## Interface
Parameters: none (RV32I, 32-bit datapath fixed).

- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset; one clock domain, synchronous, active-high
- pen_p_3  in  1  pipeline entry valid
- rad_p_3  in  5  destination register
- rad_zero_p_3  in  1  destination is x0
- alu_p_3  in  32  ALU result; effective address for loads/stores
- rd2_p_3  in  32  store data
- next_pc_p_3  in  32  link value for jal/jalr
- instr_p_3  in  32  instruction; funct3 = instr_p_3[14:12]
- is_p_3  in  15  one-hot class: [5] load, [6] store, [7] branch, [8] jal, [9] jalr; others ALU/lui/auipc/system
- stall  out  1  combinational; upstream holds all *_p_3 inputs stable while high
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, {alu[31:2],2'b00}
- dmem_wmask  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete this cycle; dmem_rdata valid with it
- dmem_rdata  in  32  load word
- rf_we  out  1  register write enable, 1-cycle pulse
- rf_wa  out  5  write address
- rf_wd  out  32  write data
- trap  out  1  1-cycle misaligned/illegal-access pulse
- retire  out  1  1-cycle pulse per completed instruction

## Operation
- FSM: IDLE, ACCESS.
- IDLE, pen_p_3=0: no action.
- IDLE, pen=1, not load/store:
  - retire<=1.
  - rf_we<=!rad_zero_p_3 & !is[6] & !is[7]; rf_wa<=rad_p_3.
  - rf_wd<=next_pc_p_3 if is[8]|is[9], else alu_p_3.
- IDLE, pen=1, load/store, legal and aligned:
  - Latch funct3, addr[1:0], rad, rad_zero.
  - dmem_req<=1, dmem_we<=is[6], dmem_addr, mask, wdata; go to ACCESS.
- Store lanes, a = addr[1:0]:
  - SB(000): mask 0001<<a, wdata {4{rd2[7:0]}}.
  - SH(001): mask 0011<<a, wdata {2{rd2[15:0]}}.
  - SW(010): mask 1111, wdata rd2.
  - Loads drive mask 0000.
- Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
- Misaligned: halfword with a[0]=1; word with a≠0.
- Illegal funct3 or misaligned: no bus access, rf_we=0, trap<=1, retire<=1, stay IDLE.
- ACCESS, dmem_ack=0: hold all dmem_* outputs unchanged.
- ACCESS, dmem_ack=1:
  - dmem_req<=0, retire<=1, state<=IDLE.
  - Load: rf_we<=!rad_zero latched, rf_wd<=extracted lane of dmem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; byte lane a, halfword lane a[1].
- stall = (IDLE & pen & load/store & legal & aligned) | (ACCESS & !dmem_ack).
- clr (any state, including mid-ACCESS): state IDLE; all registered outputs 0; an ack arriving after clr is ignored.

## Timing
- Reset values: dmem_req, dmem_we, dmem_addr, dmem_wmask, dmem_wdata, rf_we, rf_wa, rf_wd, trap, retire all 0. stall=0 after reset while pen_p_3=0.
- Non-memory: accepted at edge N; rf_we/retire high during cycle N+1 only.
- Load/store: accepted at edge N; dmem_req high from N+1 until the edge sampling dmem_ack=1 (edge M ≥ N+1). rf_we (loads) and retire are high in cycle M+1; dmem_req low from M+1.
- Minimum memory-op latency: 2 cycles; bus wait states add 1 cycle each.
- stall falls in the ack cycle, so the next instruction enters at edge M with no bubble.
- dmem_ack while IDLE is ignored.

## Test plan
- Reset: assert clr 2 cycles with random inputs -> all outputs 0, state IDLE.
- ALU op: pen=1, rad=5, alu=0x1234_5678 -> next cycle rf_we=1, rf_wa=5, rf_wd=0x12345678, retire=1; repeat with rad_zero=1 -> rf_we=0, retire=1.
- LB: addr 0x103, rdata 0x80FF_0000, ack after 3 wait cycles -> stall high 4 cycles; rf_wd=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH: addr 0x202, rd2=0xAAAA_BEEF -> dmem_addr=0x200, wmask=1100, wdata=0xBEEF_BEEF, dmem_we=1; no rf_we.
- Misaligned LW at 0x101 -> trap=1 one cycle, dmem_req stays 0, stall 0, rf_we 0.
- clr during ACCESS, then ack -> outputs 0, no rf_we, no retire; a following ALU op completes normally.
